duty_feeder: RTL and testbench
==============================

DUTY_FEEDER -- requirements
Module: duty_feeder

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning duty-cycle width in bits.
REQ-002 The module SHALL have parameter W, default 16, meaning signed audio sample width in bits (W > N).
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning sample FIFO depth (power of two, >= 2).
REQ-004 The module SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 The module SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 The module SHALL have port ena  input  1  global enable.
REQ-007 The module SHALL have port s_data  input  W  two's-complement audio sample.
REQ-008 The module SHALL have port s_valid  input  1  sample offered.
REQ-009 The module SHALL have port s_ready  output  1  sample accepted when high with s_valid.
REQ-010 The module SHALL have port period_start  input  1  one-cycle strobe at each PWM period boundary.
REQ-011 The module SHALL have port vol  input  3  attenuation, arithmetic right shift 0..7.
REQ-012 The module SHALL have port duty  output  N  unsigned duty word to the pwm stage.
REQ-013 The module SHALL have port underrun  output  1  one-cycle pulse, period boundary with no sample.
REQ-014 The module SHALL have port level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-015 s_ready SHALL equal ena AND (level < DEPTH), derived only from registered state; no bypass on a same-cycle pop.
REQ-016 A push SHALL occur when s_valid and s_ready are both high; the raw sample is stored in arrival order.
REQ-017 A pop SHALL occur when period_start, ena and (level > 0) are all high; push and pop in the same cycle SHALL leave level unchanged.
REQ-018 The popped sample SHALL be converted in the pop cycle: shifted = s_data >>> vol, using vol sampled that cycle.
REQ-019 Rounding SHALL add 2^(W-N-1) to shifted; a positive overflow SHALL saturate to 2^(W-1)-1; no negative overflow is possible.
REQ-020 duty SHALL be the top N bits of the rounded value with the MSB inverted (offset binary); 0 maps to 2^(N-1).
REQ-021 duty SHALL update exactly one cycle after the pop cycle and hold until the next pop.
REQ-022 period_start with ena high and level == 0 SHALL leave duty unchanged and assert underrun for exactly the following cycle.
REQ-023 A push coinciding with an underrun period_start SHALL be stored (level 0 -> 1) and SHALL NOT be popped in that cycle.
REQ-024 With ena low: no push, no pop, no underrun; duty, FIFO contents and level SHALL hold.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or drop below 0.

Reset
REQ-026 On rst low, asynchronously: duty = 2^(N-1), level = 0, FIFO pointers = 0, underrun = 0, s_ready = 0.
REQ-027 Reset mid-operation SHALL discard all buffered samples; no pop SHALL be produced in the first cycle after release.

Structure
REQ-028 Shared package amp_pkg SHALL hold the defaults for N, W and DEPTH, and the MIDSCALE constant 2^(N-1).
REQ-029 Storage SHALL be a sub-module sample_fifo (push/pop/level, synchronous, same reset); conversion and the duty register SHALL stay in duty_feeder.

Verification (W=16, N=8, DEPTH=4)
REQ-030 Reset: hold rst low -> duty=0x80, level=0, s_ready=0; release with ena=1 -> s_ready=1 next cycle.
REQ-031 Conversion, vol=0, each followed by period_start: 0x0000 -> duty 0x80; 0x7FFF -> 0xFF (saturated); 0x8000 -> 0x00. With vol=2: 0x1234 -> 0x85; each duty appears 1 cycle after the strobe.
REQ-032 Full: push 4 samples -> level=4, s_ready=0; hold 5th s_valid -> accepted only in the cycle after a period_start pop; order preserved.
REQ-033 Underrun: level=0, period_start -> underrun high one cycle later for 1 cycle, duty unchanged.
REQ-034 Simultaneous: level=0, push 0x4000 and period_start in the same cycle -> underrun pulse, level=1; next period_start -> duty 0xC0.
REQ-035 ena=0 with level=2 and 3 period_start strobes -> duty, level unchanged, s_ready=0, no underrun.

Source files
------------

// File: rtl/amp_pkg.sv
// Shared defaults for the audio-to-PWM duty feeder and its sample FIFO.
package amp_pkg;

  localparam int N_DEF     = 8;
  localparam int W_DEF     = 16;
  localparam int DEPTH_DEF = 4;
  localparam int MIDSCALE  = 1 << (N_DEF - 1);

  function automatic int midscale(input int n);
    return 1 << (n - 1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with occupancy count; pointers wrap modulo DEPTH.
module sample_fifo
  import amp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  // Guard against overfill/underflow even if the caller misbehaves.
  assign push_ok = push && (level_q != LW'(DEPTH));
  assign pop_ok  = pop && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/duty_feeder.sv
// Buffers signed audio samples and converts one per PWM period into an
// offset-binary duty word, with volume shift, rounding and saturation.
module duty_feeder
  import amp_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [W-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          period_start,
  input  logic [2:0]    vol,
  output logic [N-1:0]  duty,
  output logic          underrun,
  output logic [LW-1:0] level
);

  localparam logic [N-1:0] MID = N'(midscale(N));
  localparam logic [W:0]   RND = (W + 1)'(1) << (W - N - 1);
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W - 1){1'b1}}};

  logic                run_q, run_d;
  logic [N-1:0]        duty_q, duty_d;
  logic                underrun_q, underrun_d;
  logic                push, pop;
  logic [W-1:0]        fifo_dout;
  logic [LW-1:0]       fifo_level;
  logic signed [W-1:0] shifted;
  logic [W:0]          sum;
  logic                pos_ovf;
  logic [W-1:0]        sat;

  // run_q keeps the block quiet for the first cycle after reset release.
  assign s_ready = ena && run_q && (fifo_level < LW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = period_start && ena && run_q && (fifo_level != '0);

  sample_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (fifo_level)
  );

  // Only the rounding add can overflow, and only in the positive direction.
  always_comb begin
    shifted = $signed(fifo_dout) >>> vol;
    sum     = {shifted[W-1], shifted} + RND;
    pos_ovf = ~sum[W] & sum[W-1];
    sat     = pos_ovf ? POS_MAX : sum[W-1:0];
  end

  always_comb begin
    run_d      = 1'b1;
    duty_d     = duty_q;
    underrun_d = period_start && ena && run_q && (fifo_level == '0);
    if (pop) duty_d = N'(sat >> (W - N)) ^ MID;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      duty_q     <= MID;
      underrun_q <= 1'b0;
    end else begin
      run_q      <= run_d;
      duty_q     <= duty_d;
      underrun_q <= underrun_d;
    end
  end

  assign duty     = duty_q;
  assign underrun = underrun_q;
  assign level    = fifo_level;

endmodule

// File: tb/tb_duty_feeder.sv
// Directed bench for duty_feeder: stimulus queues expected strobe results,
// a negedge monitor pops and compares them and checks hold/idle behaviour.
module tb_duty_feeder;

  localparam int N     = 8;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          period_start = 1'b0;
  logic [2:0]    vol = 3'd0;
  logic [N-1:0]  duty;
  logic          underrun;
  logic [LW-1:0] level;

  duty_feeder #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .period_start (period_start),
    .vol          (vol),
    .duty         (duty),
    .underrun     (underrun),
    .level        (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [N-1:0] duty;
    logic         und;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [N-1:0] cur_duty = 8'h80;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      cur_duty = 8'h80;
      check("reset_duty", duty, 8'h80);
      check("reset_underrun", underrun, 0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("strobe_duty", duty, e.duty);
      check("strobe_underrun", underrun, e.und);
      cur_duty = e.duty;
    end else begin
      check("hold_duty", duty, cur_duty);
      check("idle_underrun", underrun, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input logic [N-1:0] d, input logic u);
    exp_t e;
    e.due  = cyc + 1;
    e.duty = d;
    e.und  = u;
    exp_q.push_back(e);
  endtask

  task automatic strobe(input logic [N-1:0] d, input logic u);
    period_start = 1'b1;
    expect_strobe(d, u);
    step();
    period_start = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] x);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = x;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL push_timeout: s_ready never rose for 0x%0h", x);
        break;
      end
    end
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and release
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", level, 0);
    check("reset_ready", s_ready, 0);
    check("reset_duty_direct", duty, 8'h80);
    rst = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", s_ready, 0);
    step();
    check("ready_after_release", s_ready, 1);

    // conversion
    push(16'h0000); strobe(8'h80, 1'b0);
    push(16'h7FFF); strobe(8'hFF, 1'b0);
    push(16'h8000); strobe(8'h00, 1'b0);
    push(16'h1234); vol = 3'd2; strobe(8'h85, 1'b0); vol = 3'd0;

    // underrun
    check("empty_before_underrun", level, 0);
    strobe(8'h85, 1'b1);
    step(); step();

    // full and back-pressure
    push(16'h1000); push(16'h2000); push(16'h3000); push(16'h4000);
    check("full_level", level, 4);
    check("full_ready", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 16'h5000;
    repeat (3) begin
      step();
      check("full_hold_level", level, 4);
      check("full_hold_ready", s_ready, 0);
    end
    period_start = 1'b1;
    expect_strobe(8'h90, 1'b0);
    @(negedge clk);
    check("no_bypass_ready", s_ready, 0);
    step();
    period_start = 1'b0;
    check("ready_after_pop", s_ready, 1);
    check("level_after_pop", level, 3);
    step();
    s_valid = 1'b0;
    check("refill_level", level, 4);
    strobe(8'hA0, 1'b0);
    strobe(8'hB0, 1'b0);
    strobe(8'hC0, 1'b0);
    strobe(8'hD0, 1'b0);
    check("drained_level", level, 0);

    // push coinciding with an underrun strobe
    s_valid = 1'b1;
    s_data  = 16'h4000;
    period_start = 1'b1;
    expect_strobe(8'hD0, 1'b1);
    step();
    s_valid = 1'b0;
    period_start = 1'b0;
    check("simul_level", level, 1);
    strobe(8'hC0, 1'b0);
    check("simul_drained", level, 0);

    // disabled: nothing moves
    push(16'h6000); push(16'h7000);
    check("pre_disable_level", level, 2);
    ena = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h1000;
    repeat (3) begin
      period_start = 1'b1;
      step();
      period_start = 1'b0;
      step();
      check("disabled_level", level, 2);
      check("disabled_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    ena = 1'b1;
    strobe(8'hE0, 1'b0);
    strobe(8'hF0, 1'b0);

    // reset mid-operation discards the buffer
    push(16'h2000); push(16'h3000);
    check("pre_reset_level", level, 2);
    rst = 1'b0;
    #1;
    check("async_reset_level", level, 0);
    check("async_reset_duty", duty, 8'h80);
    check("async_reset_ready", s_ready, 0);
    step();
    period_start = 1'b1;
    rst = 1'b1;
    step();
    period_start = 1'b0;
    check("post_reset_level", level, 0);
    push(16'h4000);
    strobe(8'hC0, 1'b0);

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
